// File: rtl/bcd_converter.sv
// rtl/bcd_converter.sv - registered 8-bit binary to 3-digit BCD converter (double-dabble core)
module bcd_converter (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  output logic [1:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       valid
);

  // Declaration initialisers give the all-zero power-up state before any reset.
  logic [1:0] hundreds_q = 2'd0;
  logic [3:0] tens_q     = 4'd0;
  logic [3:0] ones_q     = 4'd0;
  logic       valid_q    = 1'b0;

  // Combinational conversion result feeding the output registers.
  logic [9:0] bcd;

  // A digit field of 5 or more doubles to 10 or more on the next shift, so add 3
  // beforehand to make the carry land in the next decimal field.
  function automatic logic [3:0] dabble(input logic [3:0] digit);
    if (digit >= 4'd5) begin
      return digit + 4'd3;
    end
    return digit;
  endfunction

  // Double-dabble: eight unrolled correct-then-shift iterations, MSB of value first.
  // The hundreds field tops out at 2 for an 8-bit input, so it is never corrected,
  // and bit 9 is always zero until the final shift, so dropping it is lossless.
  always_comb begin
    bcd = 10'd0;
    for (int i = 0; i < 8; i++) begin
      bcd[7:4] = dabble(bcd[7:4]);
      bcd[3:0] = dabble(bcd[3:0]);
      bcd      = {bcd[8:0], value[3'(7 - i)]};
    end
  end

  // Register the digits every edge; reset wins over the sampled value.
  always_ff @(posedge clk) begin
    if (reset) begin
      hundreds_q <= 2'd0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      valid_q    <= 1'b0;
    end else begin
      hundreds_q <= bcd[9:8];
      tens_q     <= bcd[7:4];
      ones_q     <= bcd[3:0];
      valid_q    <= 1'b1;
    end
  end

  assign hundreds = hundreds_q;
  assign tens     = tens_q;
  assign ones     = ones_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_bcd_converter.sv
// tb/tb_bcd_converter.sv - self-checking bench for bcd_converter against an arithmetic model
module tb_bcd_converter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] value;
  logic [1:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       valid;

  int checks   = 0;
  int failures = 0;

  // Arithmetic reference: what the registered outputs must be after the last edge.
  bit   model_known = 1'b0;
  int   exp_h = 0;
  int   exp_t = 0;
  int   exp_o = 0;
  int   exp_valid = 0;

  // Hand-computed expectations posted by the stimulus, checked by the compare process.
  int    lit_seq  = 0;
  int    lit_done = 0;
  int    lit_h, lit_t, lit_o, lit_v;
  string lit_name;

  bcd_converter dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  // Reference model: decimal digits from division, updated on each rising edge.
  always @(posedge clk) begin
    model_known <= 1'b1;
    if (reset) begin
      exp_h     <= 0;
      exp_t     <= 0;
      exp_o     <= 0;
      exp_valid <= 0;
    end else begin
      exp_h     <= int'(value) / 100;
      exp_t     <= (int'(value) / 10) % 10;
      exp_o     <= int'(value) % 10;
      exp_valid <= 1;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Compare process: sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (model_known) begin
      chk("model_hundreds", int'(hundreds), exp_h);
      chk("model_tens",     int'(tens),     exp_t);
      chk("model_ones",     int'(ones),     exp_o);
      chk("model_valid",    int'(valid),    exp_valid);
    end
    if (lit_seq != lit_done) begin
      chk({lit_name, "_hundreds"}, int'(hundreds), lit_h);
      chk({lit_name, "_tens"},     int'(tens),     lit_t);
      chk({lit_name, "_ones"},     int'(ones),     lit_o);
      chk({lit_name, "_valid"},    int'(valid),    lit_v);
      lit_done = lit_seq;
    end
  end

  task automatic step(input logic [7:0] v, input logic r);
    value = v;
    reset = r;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_lit(input string name, input int h, input int t, input int o, input int v);
    lit_name = name;
    lit_h    = h;
    lit_t    = t;
    lit_o    = o;
    lit_v    = v;
    lit_seq++;
  endtask

  typedef struct {
    logic [7:0] v;
    int         h;
    int         t;
    int         o;
  } vec_t;

  vec_t bounds [8] = '{
    '{8'd0,   0, 0, 0},
    '{8'd9,   0, 0, 9},
    '{8'd10,  0, 1, 0},
    '{8'd99,  0, 9, 9},
    '{8'd100, 1, 0, 0},
    '{8'd199, 1, 9, 9},
    '{8'd200, 2, 0, 0},
    '{8'd255, 2, 5, 5}
  };

  initial begin
    value = 8'hFF;
    reset = 1'b1;

    // Reset held with all-ones input, then released.
    step(8'hFF, 1'b1);
    step(8'hFF, 1'b1);
    expect_lit("reset_hold", 0, 0, 0, 0);
    step(8'hFF, 1'b0);
    expect_lit("reset_release", 2, 5, 5, 1);

    // Decimal boundaries.
    foreach (bounds[i]) begin
      step(bounds[i].v, 1'b0);
      expect_lit($sformatf("bound_%0d", bounds[i].v), bounds[i].h, bounds[i].t, bounds[i].o, 1);
    end

    // Latency: a new input is not visible until the following edge.
    step(8'd123, 1'b0);
    expect_lit("lat_123", 1, 2, 3, 1);
    value = 8'd45;
    expect_lit("lat_before", 1, 2, 3, 1);
    @(posedge clk);
    #2;
    expect_lit("lat_after", 0, 4, 5, 1);

    // Back-to-back sweep of every code; the model checks each cycle.
    for (int i = 0; i < 256; i++) begin
      step(8'(i), 1'b0);
    end
    expect_lit("sweep_end", 2, 5, 5, 1);

    // Reset in the middle of a stream, then recovery with the same input.
    step(8'd255, 1'b0);
    step(8'd255, 1'b1);
    expect_lit("mid_reset", 0, 0, 0, 0);
    step(8'd255, 1'b0);
    expect_lit("mid_recover", 2, 5, 5, 1);

    // Register-value example from the CPU flow: 0xAB = 171.
    step(8'hAB, 1'b0);
    expect_lit("cpu_ab", 1, 7, 1, 1);

    @(negedge clk);
    #1;
    if (lit_seq != lit_done) begin
      checks++;
      failures++;
      $display("FAIL lit_pending actual=%0d required=%0d", lit_done, lit_seq);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
